// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction-fetch memory model: req/gnt/rvalid with configurable grant/response latency.
// Optional IMEM_RAND_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module instruction_memory_pipelined #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned GNT_DELAY       = 1,
  parameter int unsigned RESP_DELAY      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerr_o
);

  localparam int unsigned OFF    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WIDX_W = ADDR_WIDTH - OFF;
  localparam int unsigned MEM_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned GW     = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);

  if (DATA_WIDTH % 8 != 0) begin : g_err_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RESP_DELAY < 1) begin : g_err_rd
    $error("RESP_DELAY must be at least 1");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RESP_DELAY) begin : g_err_mo
    $error("MAX_OUTSTANDING must be within 1..RESP_DELAY");
  end

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  initial begin
    for (int unsigned i = 0; i < NUM_WORDS; i++) mem[i] = '0;
  end

  logic [GW-1:0]         gcnt;
  logic [OW-1:0]         outstanding;
  logic [RESP_DELAY-1:0] vld;
  logic [WIDX_W-1:0]     wq [RESP_DELAY];
  logic [WIDX_W-1:0]     widx;
  logic [WIDX_W-1:0]     last_widx;
  logic [MEM_AW-1:0]     rd_idx;
  logic                  gcnt_full;
  logic                  retiring;
  logic                  room;
  logic                  stall;
  logic                  last_err;

  if (OFF > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^addr_i[OFF-1:0];
  end

  assign widx      = addr_i[ADDR_WIDTH-1:OFF];
  assign gcnt_full = (32'(gcnt) == GNT_DELAY);
  assign retiring  = vld[RESP_DELAY-1];
  // Retiring frees a slot in the same cycle, so a full model can still grant.
  assign room      = retiring || (32'(outstanding) < MAX_OUTSTANDING);

`ifdef IMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt_o = rst_n & req_i & gcnt_full & room & ~stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt        <= '0;
      outstanding <= '0;
      vld         <= '0;
      for (int unsigned i = 0; i < RESP_DELAY; i++) wq[i] <= '0;
    end else begin
      if (!req_i || gnt_o) gcnt <= '0;
      else if (!gcnt_full) gcnt <= gcnt + 1'b1;

      if (gnt_o && !retiring)      outstanding <= outstanding + 1'b1;
      else if (!gnt_o && retiring) outstanding <= outstanding - 1'b1;

      vld[0] <= gnt_o;
      wq[0]  <= widx;
      for (int unsigned i = 1; i < RESP_DELAY; i++) begin
        vld[i] <= vld[i-1];
        wq[i]  <= wq[i-1];
      end
    end
  end

  assign last_widx = wq[RESP_DELAY-1];
  assign rd_idx    = MEM_AW'(last_widx);
  assign last_err  = (32'(last_widx) >= NUM_WORDS);

  always_comb begin
    rvalid_o = retiring;
    rerr_o   = 1'b0;
    rdata_o  = '0;
    if (retiring) begin
      rerr_o = last_err;
      if (!last_err) rdata_o = mem[rd_idx];
    end
  end

endmodule
